chain_packet_tx: RTL
====================

Name: chain_packet_tx

Overview:
Serializes a full layer vector into the per-row daisy-chain packet format {ready, id, value} and drives it onto the chain edge, one element per packet.
- Sits at the chain boundary (index -1 / DIM end) and injects host or previous-stage vectors into a core row.
- Packet spacing lets each receiving core see ready fall between packets, which its RECV -> DAISY transition requires.
- Honours a stall input so injection never collides with traffic already on the edge bus.

Parameters:
DIM, 4, number of vector elements, and packets per vector (>=2)
BITW, 16, element width in bits (fixed-point, passed through unmodified)
GAP, 1, idle cycles with pkt_ready=0 inserted after every packet (>=0; 0 = back-to-back)
IDW, $clog2(DIM), width of packet id field (derived; must match core in_*_id width)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
vec_valid  input  1  vector offered on vec
vec_ready  output  1  block can accept a vector; high only in IDLE
vec  input  DIM x BITW  vector elements, index 0..DIM-1
stall  input  1  bus occupied; defers launch of the next packet
pkt_ready  output  1  packet present on chain bus
pkt_id  output  IDW  element index of current packet
pkt_data  output  BITW  element value of current packet
busy  output  1  high from accept until done pulse inclusive
done  output  1  one-cycle pulse after last packet's trailing gap

Behaviour:
- All outputs registered except vec_ready, which is decoded from state.
- Reset (async, any time, including mid-vector):
  - state=IDLE, index=0, buffer cleared.
  - pkt_ready=0, pkt_id=0, pkt_data=0, busy=0, done=0; vec_ready=1 once reset deasserts.
  - The partial vector is discarded and never resumed.
- States: IDLE, LAUNCH, SEND, GAP, DONE.
- IDLE:
  - vec_ready=1.
  - On an edge with vec_valid=1: capture all DIM elements into the buffer, index=0, busy<=1, go to LAUNCH.
  - vec changes after the capture edge are ignored.
- LAUNCH (vec_ready=0, pkt_ready=0):
  - stall=1: remain in LAUNCH.
  - stall=0: next edge drives pkt_ready=1, pkt_id=index, pkt_data=buffer[index]; go to SEND.
- SEND:
  - Packet is held for exactly one cycle; stall is not sampled here.
  - Next edge: pkt_ready=0; pkt_id and pkt_data are driven to 0.
  - GAP>0: go to GAP with gap counter=GAP-1.
  - GAP=0: advance index directly, as at the end of GAP.
- GAP:
  - Counter decrements once per cycle.
  - At 0: if index==DIM-1, go to DONE; else index+1, go to LAUNCH.
- DONE:
  - done=1 for exactly one cycle, busy still 1.
  - Next edge: done=0, busy=0, state IDLE.
  - No vector is accepted in the DONE cycle.
- Latency, no stall:
  - Accept at edge T -> first pkt_ready high in the cycle after edge T+1.
  - Packet k is high in cycle T+2+k*(GAP+2).
  - done is high DIM*(GAP+2)+1 cycles after accept.
- Stall:
  - Affects only LAUNCH; extends the gap and never truncates a packet.
  - A stall rising during SEND takes effect on the next LAUNCH.
- GAP=0 path: SEND -> LAUNCH still yields one low cycle between packets, so pkt_ready is never high two consecutive cycles.
- Packet field ordering on the bus: {pkt_ready, pkt_id, pkt_data}, width 1+IDW+BITW.

Test Plan:
- Basic send: DIM=4, GAP=1, vec={0x009D,0x01AA,0x0120,0xFE80}, no stall.
  - Four pkt_ready pulses, ids 0,1,2,3, data matching in order, each high exactly 1 cycle, 2 low cycles between pulses.
  - done one cycle after the final gap; busy low the following cycle.
- Stall hold: assert stall before packet 2 for 5 cycles.
  - pkt_ready stays 0 throughout; packet 2 (id 2, 0x0120) appears the edge after stall falls.
  - Packet 1 is unaffected.
- Handshake: hold vec_valid=1 continuously with two different vectors.
  - vec_ready is 0 from accept through done.
  - The second vector is accepted only in IDLE after done, and its ids restart at 0.
  - Changing vec mid-transfer does not alter pkt_data.
- Reset mid-vector: assert reset asynchronously between packets 1 and 2.
  - All outputs go 0 immediately.
  - After release, vec_ready=1 and a new vector sends ids starting at 0.
- GAP=0 build: DIM=2, vec={0x0100,0xFF00}.
  - Packets in cycles T+2 and T+4 with one low cycle between.
  - done at T+5.
- Ring integration: drive a 4-core row's left edge with this block.
  - Every core's layer_out_ready rises.
  - Each core's layer_out equals the injected vector.

Source files
------------

// File: rtl/chain_packet_tx.sv
// Serializes a captured DIM-element vector onto the row daisy-chain edge as
// {ready, id, value} packets, one element per packet with idle spacing between.
module chain_packet_tx #(
    parameter int DIM  = 4,
    parameter int BITW = 16,
    parameter int GAP  = 1,
    parameter int IDW  = $clog2(DIM)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      vec_valid_i,
    output logic                      vec_ready_o,
    input  logic [DIM-1:0][BITW-1:0]  vec_i,
    input  logic                      stall_i,
    output logic                      pkt_ready_o,
    output logic [IDW-1:0]            pkt_id_o,
    output logic [BITW-1:0]           pkt_data_o,
    output logic                      busy_o,
    output logic                      done_o
);

    // The gap counter only ever holds GAP-1 down to 0.
    localparam int GCW = (GAP > 2) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [IDW-1:0]             index_q, index_d;
    logic [GCW-1:0]             gapCnt_q, gapCnt_d;
    logic [DIM-1:0][BITW-1:0]   buffer_q, buffer_d;
    logic                       pktReady_q, pktReady_d;
    logic [IDW-1:0]             pktId_q, pktId_d;
    logic [BITW-1:0]            pktData_q, pktData_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       lastElem;

    assign lastElem = (index_q == IDW'(DIM - 1));

    // State and all registered outputs; reset drops any partial vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            gapCnt_q   <= '0;
            buffer_q   <= '0;
            pktReady_q <= 1'b0;
            pktId_q    <= '0;
            pktData_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            gapCnt_q   <= gapCnt_d;
            buffer_q   <= buffer_d;
            pktReady_q <= pktReady_d;
            pktId_q    <= pktId_d;
            pktData_q  <= pktData_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Packet fields default to zero so the bus reads idle between packets.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        gapCnt_d   = gapCnt_q;
        buffer_d   = buffer_q;
        pktReady_d = 1'b0;
        pktId_d    = '0;
        pktData_d  = '0;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (vec_valid_i) begin
                    buffer_d = vec_i;
                    index_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (!stall_i) begin
                    pktReady_d = 1'b1;
                    pktId_d    = index_q;
                    pktData_d  = buffer_q[index_q];
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (GAP > 0) begin
                    gapCnt_d = GCW'((GAP > 0) ? GAP - 1 : 0);
                    state_d  = ST_GAP;
                end else if (lastElem) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q + IDW'(1);
                    state_d = ST_LAUNCH;
                end
            end
            ST_GAP: begin
                if (gapCnt_q != '0) begin
                    gapCnt_d = gapCnt_q - GCW'(1);
                end else if (lastElem) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q + IDW'(1);
                    state_d = ST_LAUNCH;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Held low while reset is asserted so nothing is offered mid-reset.
    assign vec_ready_o = (state_q == ST_IDLE) && !reset;
    assign pkt_ready_o = pktReady_q;
    assign pkt_id_o    = pktId_q;
    assign pkt_data_o  = pktData_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
